sipo_deframer: RTL and testbench

- Serial-in/parallel-out receiver that sits directly downstream of the PISO serializer.
- Samples the serializer's one-bit output on strobed clock edges and reassembles WIDTH-bit words.
- Buffers completed words in a small FIFO and presents them on a valid/ready parallel interface.
- Flags overflow and framing errors in sticky status bits.

---
 rtl/sipo_deframer.sv | 78 +++++++
 tb/tb_sipo_deframer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer: reassembles WIDTH-bit words from a strobed
// bit stream and buffers them in a first-word-fall-through FIFO.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ser_in,
  input  logic                    ser_valid,
  input  logic                    ser_start,
  output logic [WIDTH-1:0]        par_data,
  output logic                    par_valid,
  input  logic                    par_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    frame_err,
  input  logic                    clr_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] sr, base, word;
  logic [CW-1:0]    bit_cnt, eff_cnt;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop, full, wr;

  // A start bit restarts assembly from an empty register, so the first bit
  // of every word ends up in the same place whether or not it was flagged.
  always_comb begin
    base    = ser_start ? '0 : sr;
    eff_cnt = ser_start ? '0 : bit_cnt;
    if (MSB_FIRST != 0)
      word = (base << 1) | WIDTH'(ser_in);
    else
      word = (base >> 1) | (WIDTH'(ser_in) << (WIDTH - 1));
    push = ser_valid && (eff_cnt == CW'(WIDTH - 1));
  end

  assign par_valid = (fifo_count != '0);
  assign par_data  = par_valid ? mem[rd_ptr] : '0;
  assign full      = (fifo_count == ($clog2(DEPTH)+1)'(DEPTH));
  assign pop       = par_valid && par_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
  assign wr        = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr         <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (ser_valid) begin
        sr      <= word;
        bit_cnt <= push ? '0 : eff_cnt + 1'b1;
      end
      if (wr) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!wr && pop) fifo_count <= fifo_count - 1'b1;
      // Set beats clear when both happen in the same cycle.
      overflow  <= (push && full && !pop) || (overflow && !clr_err);
      frame_err <= (ser_valid && ser_start && (bit_cnt != '0)) || (frame_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a queue-based word/FIFO model.
module tb_sipo_deframer;

  localparam int W = 4;
  localparam int D = 2;

  logic clk = 0, rst_n, ser_in, ser_valid, ser_start, par_ready, clr_err;
  logic [W-1:0] pd1, pd0;
  logic pv1, pv0, ov1, ov0, fe1, fe0;
  logic [$clog2(D):0] fc1, fc0;

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .ser_start(ser_start),
    .par_data(pd1), .par_valid(pv1), .par_ready(par_ready), .fifo_count(fc1),
    .overflow(ov1), .frame_err(fe1), .clr_err(clr_err));

  sipo_deframer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .ser_start(ser_start),
    .par_data(pd0), .par_valid(pv0), .par_ready(par_ready), .fifo_count(fc0),
    .overflow(ov0), .frame_err(fe0), .clr_err(clr_err));

  // Model: bits of the word in progress, and the buffered words as each
  // ordering would assemble them.
  int bits[$];
  int q1[$], q0[$];
  bit m_ovf, m_ferr;
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int head(input int q[$]);
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  task automatic model_step(input bit v, s, b, r, c, rn);
    bit push, pop, full, fset, oset;
    int w1, w0;
    if (!rn) begin
      bits.delete(); q1.delete(); q0.delete(); m_ovf = 0; m_ferr = 0;
      return;
    end
    pop = (q1.size() > 0) && r;
    full = (q1.size() == D);
    push = 0; fset = 0; w1 = 0; w0 = 0;
    if (v) begin
      if (s) begin
        fset = (bits.size() != 0);
        bits.delete();
      end
      bits.push_back(b);
      if (bits.size() == W) begin
        push = 1;
        for (int i = 0; i < W; i++) begin
          w1 += bits[i] << (W - 1 - i);
          w0 += bits[i] << i;
        end
        bits.delete();
      end
    end
    oset = push && full && !pop;
    if (pop) begin void'(q1.pop_front()); void'(q0.pop_front()); end
    if (push && !oset) begin q1.push_back(w1); q0.push_back(w0); end
    m_ovf  = oset || (m_ovf && !c);
    m_ferr = fset || (m_ferr && !c);
  endtask

  task automatic compare();
    chk("valid_msb", pv1, q1.size() > 0);
    chk("valid_lsb", pv0, q0.size() > 0);
    chk("data_msb", pd1, head(q1));
    chk("data_lsb", pd0, head(q0));
    chk("count_msb", fc1, q1.size());
    chk("count_lsb", fc0, q0.size());
    chk("ovf_msb", ov1, m_ovf);
    chk("ovf_lsb", ov0, m_ovf);
    chk("ferr_msb", fe1, m_ferr);
    chk("ferr_lsb", fe0, m_ferr);
  endtask

  // One clock: drive, let the edge happen, advance the model, then compare.
  task automatic cyc(input bit v, s, b, r, c = 0, rn = 1);
    ser_valid = v; ser_start = s; ser_in = b; par_ready = r; clr_err = c; rst_n = rn;
    @(posedge clk);
    model_step(v, s, b, r, c, rn);
    #1 compare();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r, input bit st = 1);
    for (int i = W - 1; i >= 0; i--) cyc(1, (i == W - 1) && st, w[i], r);
  endtask

  initial begin
    ser_valid = 0; ser_start = 0; ser_in = 0; par_ready = 0; clr_err = 0; rst_n = 0;
    #2;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_valid", pv1, 0); chk("rst_count", fc1, 0); chk("rst_data", pd1, 0);

    // 1,0,1,1 -> B (MSB-first) / D (LSB-first)
    send_word(4'b1011, 1);
    chk("lit_B", pd1, 4'hB); chk("lit_D", pd0, 4'hD); chk("lit_cnt1", fc1, 1);
    cyc(0, 0, 0, 1);
    chk("lit_cnt0", fc1, 0);

    // overflow with consumer stalled
    send_word(4'hA, 0); send_word(4'h5, 0); send_word(4'hC, 0);
    chk("lit_ovf_cnt", fc1, 2); chk("lit_ovf", ov1, 1); chk("lit_ovf_head", pd1, 4'hA);
    cyc(0, 0, 0, 1);
    chk("lit_pop_5", pd1, 4'h5);
    cyc(0, 0, 0, 1);
    chk("lit_empty", pv1, 0);
    cyc(0, 0, 0, 1, 1);
    chk("lit_clr", ov1, 0);

    // framing error: 2 bits, then restart with 1,1,1,1
    cyc(1, 1, 0, 1); cyc(1, 0, 1, 1);
    send_word(4'hF, 1);
    chk("lit_ferr", fe1, 1); chk("lit_F", pd1, 4'hF); chk("lit_F_cnt", fc1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("lit_ferr_clr", fe1, 0);

    // full FIFO, pop coincides with completion of word 9
    send_word(4'h1, 0); send_word(4'h2, 0);
    cyc(1, 1, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 1, 1);
    chk("lit_full_cnt", fc1, 2); chk("lit_full_ovf", ov1, 0); chk("lit_full_head", pd1, 4'h2);
    cyc(0, 0, 0, 1);
    chk("lit_9", pd1, 4'h9);
    cyc(0, 0, 0, 1);

    // reset mid-word with one word buffered
    send_word(4'h3, 0);
    cyc(1, 1, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_rst_valid", pv1, 0); chk("lit_rst_cnt", fc1, 0);
    send_word(4'h6, 0, 0);
    chk("lit_fresh", pd1, 4'h6); chk("lit_fresh_ferr", fe1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, s, r, c, rn;
      v  = ($urandom_range(0, 99) < 80);
      s  = ($urandom_range(0, 99) < 10);
      r  = ($urandom_range(0, 99) < 60);
      c  = ($urandom_range(0, 99) < 5);
      rn = ($urandom_range(0, 999) >= 5);
      cyc(v, s, 1'($urandom_range(0, 1)), r, c, rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
